// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder/loader: mnemonic codes,
// MIPS opcode/funct values, load FSM states and word-packing helpers.
package instr_enc_pkg;

    typedef enum logic [4:0] {
        MN_ADD     = 5'd0,
        MN_SUB     = 5'd1,
        MN_AND     = 5'd2,
        MN_OR      = 5'd3,
        MN_SLT     = 5'd4,
        MN_JR      = 5'd5,
        MN_ADDI    = 5'd6,
        MN_BEQ     = 5'd7,
        MN_BNE     = 5'd8,
        MN_BNEZ    = 5'd9,
        MN_SLTIU   = 5'd10,
        MN_LUI     = 5'd11,
        MN_ORI     = 5'd12,
        MN_LW      = 5'd13,
        MN_SW      = 5'd14,
        MN_J       = 5'd15,
        MN_JAL     = 5'd16,
        MN_BLE     = 5'd17,
        MN_BLTZ    = 5'd18,
        MN_ILLEGAL = 5'd19
    } mnemonic_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BLTZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLE   = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_PAD  = 2'd3
    } loadState_e;

    // shamt is always zero in every word this block produces
    function automatic logic [31:0] packR(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] packI(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] packJ(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational encoder: mnemonic code plus register/immediate/target fields
// to a 32-bit MIPS instruction word, flagging codes outside the mnemonic table.
module instr_field_packer
    import instr_enc_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Pseudo-ops (bnez, bltz) and lui pin their unused register field to zero
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (mnem)
            MN_ADD:   word = packR(rs, rt, rd, FN_ADD);
            MN_SUB:   word = packR(rs, rt, rd, FN_SUB);
            MN_AND:   word = packR(rs, rt, rd, FN_AND);
            MN_OR:    word = packR(rs, rt, rd, FN_OR);
            MN_SLT:   word = packR(rs, rt, rd, FN_SLT);
            MN_JR:    word = packR(rs, 5'h00, 5'h00, FN_JR);
            MN_ADDI:  word = packI(OP_ADDI, rs, rt, imm);
            MN_BEQ:   word = packI(OP_BEQ, rs, rt, imm);
            MN_BNE:   word = packI(OP_BNE, rs, rt, imm);
            MN_BNEZ:  word = packI(OP_BNE, rs, 5'h00, imm);
            MN_SLTIU: word = packI(OP_SLTIU, rs, rt, imm);
            MN_LUI:   word = packI(OP_LUI, 5'h00, rt, imm);
            MN_ORI:   word = packI(OP_ORI, rs, rt, imm);
            MN_LW:    word = packI(OP_LW, rs, rt, imm);
            MN_SW:    word = packI(OP_SW, rs, rt, imm);
            MN_J:     word = packJ(OP_J, target);
            MN_JAL:   word = packJ(OP_JAL, target);
            MN_BLE:   word = packI(OP_BLE, rs, rt, imm);
            MN_BLTZ:  word = packI(OP_BLTZ, rs, 5'h00, imm);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction requests and streams them into instruction memory at
// incrementing byte addresses. Define INSTR_ENC_NOP_PAD_EN to NOP-pad on finish.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       finish_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [4:0]                 mnem_i,
    input  logic [4:0]                 rs_i,
    input  logic [4:0]                 rt_i,
    input  logic [4:0]                 rd_i,
    input  logic [15:0]                imm_i,
    input  logic [25:0]                target_i,
    output logic                       wr_en_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic [31:0]                wr_data_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       busy_o
);

    localparam int                 CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0]  BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]  WORD_STEP = ADDR_W'(4);

    loadState_e        state;
    loadState_e        stateNext;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       packedWord;
    logic              packedIllegal;
    logic              reqReady;
    logic              doWrite;
    logic              doIllegal;
    logic              clearWindow;
    logic [31:0]       writeWord;
    logic              wrEnQ;
    logic [ADDR_W-1:0] wrAddrQ;
    logic [31:0]       wrDataQ;
    logic              illegalQ;

    instr_field_packer uPacker (
        .mnem    (mnem_i),
        .rs      (rs_i),
        .rt      (rt_i),
        .rd      (rd_i),
        .imm     (imm_i),
        .target  (target_i),
        .word    (packedWord),
        .illegal (packedIllegal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // finish_i wins over the FULL transition so a closing request never strands the FSM in FULL
    always_comb begin
        stateNext   = state;
        reqReady    = 1'b0;
        doWrite     = 1'b0;
        doIllegal   = 1'b0;
        clearWindow = 1'b0;
        writeWord   = packedWord;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    stateNext   = ST_LOAD;
                    clearWindow = 1'b1;
                end
            end
            ST_LOAD: begin
                reqReady = (count < DEPTH_CNT);
                if (req_valid_i && reqReady) begin
                    doWrite   = !packedIllegal;
                    doIllegal = packedIllegal;
                end
                if (finish_i) begin
`ifdef INSTR_ENC_NOP_PAD_EN
                    stateNext = ST_PAD;
`else
                    stateNext = ST_IDLE;
`endif
                end else if (doWrite && (count == LAST_CNT)) begin
                    stateNext = ST_FULL;
                end
            end
            ST_FULL: begin
                if (finish_i) begin
                    stateNext = ST_IDLE;
                end
            end
            ST_PAD: begin
`ifdef INSTR_ENC_NOP_PAD_EN
                writeWord = '0;
                doWrite   = (count < DEPTH_CNT);
                if (count >= LAST_CNT) begin
                    stateNext = ST_IDLE;
                end
`else
                stateNext = ST_IDLE;
`endif
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // One-cycle output register; the address/count move only on real writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count    <= '0;
            addr     <= BASE;
            wrEnQ    <= 1'b0;
            wrAddrQ  <= '0;
            wrDataQ  <= '0;
            illegalQ <= 1'b0;
        end else begin
            wrEnQ    <= doWrite;
            illegalQ <= doIllegal;
            if (clearWindow) begin
                count <= '0;
                addr  <= BASE;
            end else if (doWrite) begin
                wrAddrQ <= addr;
                wrDataQ <= writeWord;
                addr    <= addr + WORD_STEP;
                count   <= count + 1'b1;
            end
        end
    end

    assign req_ready_o = reqReady;
    assign wr_en_o     = wrEnQ;
    assign wr_addr_o   = wrAddrQ;
    assign wr_data_o   = wrDataQ;
    assign illegal_o   = illegalQ;
    assign count_o     = count;
    assign busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed steps from the
// bring-up plan followed by randomized load windows against a reference model.
module tb_instr_encoder_loader;

    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 10;
    localparam int BASE_ADDR = 0;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              finish;
    logic              reqValid;
    logic              reqReady;
    logic [4:0]        mnem;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [31:0]       wrData;
    logic              illegal;
    logic [CNT_W-1:0]  count;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 loading, 2 full, 3 padding
    int expMode  = 0;
    int expCount = 0;
    int expAddr  = BASE_ADDR;

    instr_encoder_loader #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .finish_i    (finish),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .mnem_i      (mnem),
        .rs_i        (rs),
        .rt_i        (rt),
        .rd_i        (rd),
        .imm_i       (imm),
        .target_i    (target),
        .wr_en_o     (wrEn),
        .wr_addr_o   (wrAddr),
        .wr_data_o   (wrData),
        .illegal_o   (illegal),
        .count_o     (count),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic longint rFmt(input int frs, input int frt, input int frd, input int funct);
        return longint'(frs) * 2097152 + longint'(frt) * 65536 + longint'(frd) * 2048 + longint'(funct);
    endfunction

    function automatic longint iFmt(input int op, input int frs, input int frt, input int fimm);
        return longint'(op) * 67108864 + longint'(frs) * 2097152 + longint'(frt) * 65536 + longint'(fimm);
    endfunction

    function automatic longint jFmt(input int op, input int ftgt);
        return longint'(op) * 67108864 + longint'(ftgt);
    endfunction

    function automatic logic [31:0] refEncode(input int mn, input int frs, input int frt, input int frd,
                                              input int fimm, input int ftgt, output bit ill);
        longint w;
        w   = 0;
        ill = 1'b0;
        case (mn)
            0:  w = rFmt(frs, frt, frd, 32);
            1:  w = rFmt(frs, frt, frd, 34);
            2:  w = rFmt(frs, frt, frd, 36);
            3:  w = rFmt(frs, frt, frd, 37);
            4:  w = rFmt(frs, frt, frd, 42);
            5:  w = rFmt(frs, 0, 0, 8);
            6:  w = iFmt(8, frs, frt, fimm);
            7:  w = iFmt(4, frs, frt, fimm);
            8:  w = iFmt(5, frs, frt, fimm);
            9:  w = iFmt(5, frs, 0, fimm);
            10: w = iFmt(11, frs, frt, fimm);
            11: w = iFmt(15, 0, frt, fimm);
            12: w = iFmt(13, frs, frt, fimm);
            13: w = iFmt(35, frs, frt, fimm);
            14: w = iFmt(43, frs, frt, fimm);
            15: w = jFmt(2, ftgt);
            16: w = jFmt(3, ftgt);
            17: w = iFmt(6, frs, frt, fimm);
            18: w = iFmt(1, frs, 0, fimm);
            default: ill = 1'b1;
        endcase
        return w[31:0];
    endfunction

    task automatic applyStimulus(input bit st, input bit fin, input bit vld, input int mn,
                                 input int frs, input int frt, input int frd, input int fimm, input int ftgt);
        start    = st;
        finish   = fin;
        reqValid = vld;
        mnem     = 5'(mn);
        rs       = 5'(frs);
        rt       = 5'(frt);
        rd       = 5'(frd);
        imm      = 16'(fimm);
        target   = 26'(ftgt);
    endtask

    // Drain NOP padding after a finish, one model step per clock
    task automatic padDrain();
        int wasCount;
        bit padWrite;
        while (expMode == 3) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            wasCount = expCount;
            padWrite = (wasCount < DEPTH);
            @(posedge clk);
            #1;
            checkOutput("padWrEn", wrEn, padWrite);
            if (padWrite) begin
                checkOutput("padAddr", wrAddr, expAddr);
                checkOutput("padData", wrData, 32'h0000_0000);
                expCount++;
                expAddr += 4;
            end
            if (wasCount >= DEPTH - 1) expMode = 0;
            checkOutput("padCount", count, expCount);
            checkOutput("padBusy", busy, expMode != 0);
        end
    endtask

    // One clock of stimulus with full model prediction of the following cycle
    task automatic doStep(input bit st, input bit fin, input bit vld, input int mn,
                          input int frs, input int frt, input int frd, input int fimm, input int ftgt);
        bit          expReady;
        bit          accept;
        bit          ill;
        bit          expWr;
        bit          expIll;
        logic [31:0] expWord;
        int          addrBefore;
        applyStimulus(st, fin, vld, mn, frs, frt, frd, fimm, ftgt);
        #1;
        expReady = (expMode == 1) && (expCount < DEPTH);
        checkOutput("reqReady", reqReady, expReady);
        expWord    = refEncode(mn, frs, frt, frd, fimm, ftgt, ill);
        accept     = vld && expReady;
        expWr      = accept && !ill;
        expIll     = accept && ill;
        addrBefore = expAddr;
        @(posedge clk);
        #1;
        if (expWr) begin
            expCount++;
            expAddr += 4;
        end
        case (expMode)
            0: if (st) begin
                   expMode  = 1;
                   expCount = 0;
                   expAddr  = BASE_ADDR;
               end
            1: begin
`ifdef INSTR_ENC_NOP_PAD_EN
                   if (fin) expMode = 3;
`else
                   if (fin) expMode = 0;
`endif
                   else if (expWr && expCount == DEPTH) expMode = 2;
               end
            2: if (fin) expMode = 0;
            default: ;
        endcase
        checkOutput("wrEn", wrEn, expWr);
        if (expWr) begin
            checkOutput("wrAddr", wrAddr, addrBefore);
            checkOutput("wrData", wrData, expWord);
        end
        checkOutput("illegal", illegal, expIll);
        checkOutput("count", count, expCount);
        checkOutput("busy", busy, expMode != 0);
        padDrain();
    endtask

    initial begin
        int reqs;
        bit fin;
        $display("[TB] starting instr_encoder_loader bench");
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rstWrEn", wrEn, 1'b0);
        checkOutput("rstReady", reqReady, 1'b0);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstCount", count, 0);
        checkOutput("rstIllegal", illegal, 1'b0);
        checkOutput("rstData", wrData, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // add r3, r1, r2 into a fresh window
        doStep(1, 0, 0, 0, 0, 0, 0, 0, 0);
        doStep(0, 0, 1, 0, 1, 2, 3, 0, 0);
        checkOutput("planAddData", wrData, 32'h0022_1820);
        checkOutput("planAddAddr", wrAddr, 0);
        checkOutput("planAddCount", count, 1);
        doStep(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // lw then j back-to-back, bnez, jr fills the window
        doStep(1, 0, 0, 0, 0, 0, 0, 0, 0);
        doStep(0, 0, 1, 13, 4, 5, 0, 16'h0010, 0);
        checkOutput("planLwData", wrData, 32'h8C85_0010);
        doStep(0, 0, 1, 15, 0, 0, 0, 0, 26'h40);
        checkOutput("planJData", wrData, 32'h0800_0040);
        checkOutput("planJAddr", wrAddr, 4);
        doStep(0, 0, 1, 9, 6, 9, 0, 16'hFFFE, 0);
        checkOutput("planBnezData", wrData, 32'h14C0_FFFE);
        doStep(1, 0, 1, 5, 31, 0, 0, 0, 0);
        checkOutput("planJrData", wrData, 32'h03E0_0008);
        checkOutput("planFullReady", reqReady, 1'b0);
        doStep(0, 0, 1, 0, 1, 1, 1, 0, 0);
        doStep(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("planIdleBusy", busy, 1'b0);

        // illegal code, then a legal closing request with finish
        doStep(1, 0, 0, 0, 0, 0, 0, 0, 0);
        doStep(0, 0, 1, 25, 1, 2, 3, 0, 0);
        doStep(0, 1, 1, 3, 7, 8, 9, 0, 0);
        checkOutput("planAfterIllAddr", wrAddr, 0);

        // reset in the middle of a load drops the pending write
        doStep(1, 0, 0, 0, 0, 0, 0, 0, 0);
        doStep(0, 0, 1, 6, 2, 3, 0, 16'h1234, 0);
        applyStimulus(0, 0, 1, 2, 4, 5, 6, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abortWrEn", wrEn, 1'b0);
        checkOutput("abortBusy", busy, 1'b0);
        checkOutput("abortCount", count, 0);
        expMode  = 0;
        expCount = 0;
        expAddr  = BASE_ADDR;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized windows
        for (int w = 0; w < 25; w++) begin
            doStep(1, 0, 0, 0, 0, 0, 0, 0, 0);
            reqs = $urandom_range(1, 7);
            fin  = 1'b0;
            for (int i = 0; i < reqs; i++) begin
                fin = (i == reqs - 1) && ($urandom % 2 == 0);
                doStep(1'($urandom % 2), fin, 1'($urandom % 5 != 0),
                       ($urandom % 4 == 0) ? int'($urandom_range(19, 31)) : int'($urandom_range(0, 18)),
                       int'($urandom % 32), int'($urandom % 32), int'($urandom % 32),
                       int'($urandom % 65536), int'($urandom % 67108864));
            end
            if (!fin) doStep(0, 1, 0, 0, 0, 0, 0, 0, 0);
            doStep(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
